// File: rtl/signed_mac6.sv
// Signed multiply-accumulate: sequential shift-add multiplier feeding a
// saturating accumulator with a sticky saturation flag and a valid/ready
// handshake on both sides.
module signed_mac6 #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned ACC_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clr,
    output logic [2*WIDTH-1:0]   prod,
    output logic [ACC_W-1:0]     acc,
    output logic                 sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [PW-1:0]     r_pp;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW-1:0]     r_prod;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;

    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [PW-1:0]     w_mag_a_ext;
    logic              w_neg;
    logic [PW-1:0]     w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic              w_fits;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_last_iter;

    // Operand magnitudes and result sign from the latched pair
    assign w_mag_a     = r_a[WIDTH-1] ? WIDTH'(-r_a) : r_a;
    assign w_mag_b     = r_b[WIDTH-1] ? WIDTH'(-r_b) : r_b;
    assign w_mag_a_ext = PW'(w_mag_a);
    assign w_neg       = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_prod      = w_neg ? PW'(-r_pp) : r_pp;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // Wide signed sum; it fits when all bits above the accumulator sign agree
    assign w_sum  = {{(SUM_W - ACC_W){r_acc[ACC_W-1]}}, r_acc}
                  + {{(SUM_W - PW){w_prod[PW-1]}}, w_prod};
    assign w_fits = (&w_sum[SUM_W-1:ACC_W-1]) || !(|w_sum[SUM_W-1:ACC_W-1]);
    assign w_acc_next = w_fits ? w_sum[ACC_W-1:0]
                      : (w_sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}});

    // State register with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
        end
    end

    // Next-state logic; clear in IDLE blocks acceptance for that cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (!clr && in_valid) w_next = MULT;
            MULT: if (w_last_iter)      w_next = ACC;
            ACC:                        w_next = DONE;
            DONE: if (out_ready)        w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations, accumulate, clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_pp   <= '0;
            r_cnt  <= '0;
            r_prod <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end else if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_pp  <= '0;
                        r_cnt <= '0;
                    end
                end
                MULT: begin
                    if (w_mag_b[r_cnt]) r_pp <= r_pp + (w_mag_a_ext << r_cnt);
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ACC: begin
                    r_prod <= w_prod;
                    r_acc  <= w_acc_next;
                    if (!w_fits) r_sat <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign prod      = r_prod;
    assign acc       = r_acc;
    assign sat       = r_sat;

endmodule

// File: tb/tb_signed_mac6.sv
// Bench for signed_mac6: directed scenarios plus randomized pairs checked
// against an integer multiply / clamp reference model.
module tb_signed_mac6;

    localparam int WIDTH   = 6;
    localparam int ACC_W   = 10;
    localparam int LAT     = WIDTH + 1;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
    localparam int OP_MAX  = (1 << (WIDTH - 1)) - 1;
    localparam int OP_MIN  = -(1 << (WIDTH - 1));

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                in_valid;
    logic                in_ready;
    logic                clr;
    logic [2*WIDTH-1:0]  prod;
    logic [ACC_W-1:0]    acc;
    logic                sat;
    logic                out_valid;
    logic                out_ready;

    int n_vec = 0;
    int n_err = 0;
    int m_acc = 0;
    int m_sat = 0;
    int m_prod = 0;

    signed_mac6 #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr       (clr),
        .prod      (prod),
        .acc       (acc),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int s_prod();
        return int'($signed(prod));
    endfunction

    function automatic int s_acc();
        return int'($signed(acc));
    endfunction

    // Reference: exact product, clamp sum into accumulator range, sticky sat
    task automatic model_acc(input int av, input int bv);
        int s;
        m_prod = av * bv;
        s = m_acc + m_prod;
        if (s > ACC_MAX) begin s = ACC_MAX; m_sat = 1; end
        else if (s < ACC_MIN) begin s = ACC_MIN; m_sat = 1; end
        m_acc = s;
    endtask

    // Entered and left #1 after a rising edge with the DUT idle
    task automatic run_pair(input int av, input int bv, input int hold, input bit clr_mid);
        int  lat;
        bit  seen;
        chk("in_ready_idle", int'(in_ready), 1);
        a = WIDTH'(av);
        b = WIDTH'(bv);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr = clr_mid;
        chk("in_ready_busy", int'(in_ready), 0);
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            clr = 1'b0;
            if (out_valid) begin
                seen = 1'b1;
                lat = i;
            end
        end
        in_valid = 1'b0;
        chk("latency", lat, LAT);
        model_acc(av, bv);
        chk("prod", s_prod(), m_prod);
        chk("acc", s_acc(), m_acc);
        chk("sat", int'(sat), m_sat);
        chk("in_ready_done", int'(in_ready), 0);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_prod", s_prod(), m_prod);
            chk("hold_acc", s_acc(), m_acc);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
    endtask

    task automatic do_clr(input bit with_valid);
        bit any_valid;
        clr = 1'b1;
        in_valid = with_valid;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        m_acc = 0;
        m_sat = 0;
        chk("clr_acc", s_acc(), 0);
        chk("clr_sat", int'(sat), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        any_valid = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1'b1;
        end
        chk("clr_no_accept", int'(any_valid), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_prod"}, s_prod(), 0);
        chk({tag, "_acc"}, s_acc(), 0);
        chk({tag, "_sat"}, int'(sat), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 3))
            0:       return OP_MIN;
            1:       return OP_MAX;
            default: return $urandom_range(0, OP_MAX - OP_MIN) + OP_MIN;
        endcase
    endfunction

    initial begin
        bit any_valid;
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios
        run_pair(1, 2, 0, 1'b0);
        chk("dir1_prod", s_prod(), 2);
        chk("dir1_acc", s_acc(), 2);
        run_pair(-3, 2, 0, 1'b1);
        chk("dir2_prod_raw", int'(prod), 'hFFA);
        chk("dir2_acc", s_acc(), -4);
        do_clr(1'b0);
        run_pair(-32, -32, 0, 1'b0);
        chk("dir3_prod", s_prod(), 1024);
        chk("dir3_acc", s_acc(), 511);
        chk("dir3_sat", int'(sat), 1);
        run_pair(1, -1, 5, 1'b0);
        chk("dir4_acc", s_acc(), 510);
        chk("dir4_sat", int'(sat), 1);
        do_clr(1'b1);

        // Reset pulse during the fourth multiply iteration
        a = WIDTH'(7);
        b = WIDTH'(-5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_acc = 0;
        m_sat = 0;
        chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1'b1;
        end
        chk("rst_discard", int'(any_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_clr(1'($urandom));
            else run_pair(rand_op(), rand_op(), $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signed_mac6.md
SIGNED_MAC6 -- requirements
Module: signed_mac6

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the operand width in bits (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 10, the accumulator width in bits (signed two's complement).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port a  input  WIDTH  signed multiplicand.
REQ-006 SHALL have port b  input  WIDTH  signed multiplier.
REQ-007 SHALL have port in_valid  input  1  a/b valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-009 SHALL have port clr  input  1  synchronous clear of acc and sat.
REQ-010 SHALL have port prod  output  2*WIDTH  signed product of the last accepted pair.
REQ-011 SHALL have port acc  output  ACC_W  signed saturating accumulator.
REQ-012 SHALL have port sat  output  1  sticky saturation flag.
REQ-013 SHALL have port out_valid  output  1  prod/acc hold a new result.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-015 SHALL implement FSM states IDLE, MULT, ACC, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL accept a pair on a rising edge with in_valid&in_ready, latch a and b, clear the partial product, and enter MULT with iteration count 0.
REQ-018 SHALL, in MULT, perform one shift-add iteration per cycle on the operand magnitudes for exactly WIDTH cycles, then enter ACC.
REQ-019 SHALL, on the ACC edge, write prod as the exact 2*WIDTH-bit signed product (negated when operand signs differ), including -32*-32=+1024, and enter DONE.
REQ-020 SHALL, on the ACC edge, set acc to acc plus the sign-extended prod, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-021 SHALL set sat=1 on any clamped update; sat SHALL stay 1 until clr or rst.
REQ-022 SHALL keep out_valid=1 in DONE only; prod and acc SHALL be stable while out_valid=1.
REQ-023 SHALL assert out_valid exactly WIDTH+1 rising edges after the accepting edge (7 at default).
REQ-024 SHALL return from DONE to IDLE on a rising edge with out_ready=1; out_valid SHALL hold indefinitely while out_ready=0.
REQ-025 SHALL, in IDLE with clr=1, set acc=0 and sat=0 on the next edge; clr SHALL take priority over accept, so no pair is accepted that cycle.
REQ-026 SHALL ignore clr outside IDLE.
REQ-027 SHALL ignore a, b and in_valid outside IDLE; operands changing mid-MULT SHALL NOT affect the result.
REQ-028 SHALL treat acc and prod as bit-exact two's complement; no wrap-around of acc is permitted.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-MULT, immediately enter IDLE with prod=0, acc=0, sat=0, out_valid=0, in_ready=1 and iteration count 0, discarding any in-flight pair.
REQ-030 SHALL resume accepting on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL be verified for reset then a=1, b=2 accepted -> out_valid rises 7 edges later, prod=2, acc=2, sat=0.
REQ-032 SHALL be verified for acc=2 then a=-3, b=2 -> prod=-6 (12'hFFA), acc=-4.
REQ-033 SHALL be verified for acc=0 then a=-32, b=-32 -> prod=1024, acc=511, sat=1; a following a=1, b=-1 -> acc=510 with sat still 1.
REQ-034 SHALL be verified for out_ready=0 for 5 cycles in DONE -> out_valid, prod and acc constant and in_ready=0 throughout; one edge with out_ready=1 -> IDLE.
REQ-035 SHALL be verified for clr=1 with in_valid=1 in IDLE -> acc=0, sat=0, pair not accepted, in_ready still 1.
REQ-036 SHALL be verified for rst pulsed during MULT iteration 3 -> all outputs at reset values asynchronously, and no out_valid for the discarded pair.
